fft_regfile: RTL
================

# fft_regfile

Memory-mapped register window for the FFT accelerator. It decodes the eight CPU addresses 0xF8–0xFF, which the address interceptor flags with `ADR_IS_FFT`/`FFT_WRITE`, and drives the `FFT_DATA` read bus back into the interceptor's read mux. Internally it buffers input samples and results in two 8-deep FIFOs. A sequencer streams a sample frame to the FFT core over a valid/ready handshake and collects the results.

## Interface
- `DEPTH`, 8: entries per FIFO, a power of two; count fields are 4 bits wide.
- `CLK` in 1: single system clock; all state updates on its rising edge.
- `RESET` in 1: asynchronous, active-high.
- `ADR` in 3: `ADR[2:0]` from the CPU; register offset within 0xF8–0xFF.
- `WRITE_DATA` in 8: CPU write data.
- `FFT_WRITE` in 1: write strobe from the interceptor, one cycle per write.
- `FFT_READ` in 1: read strobe, high for one cycle while the CPU reads with `ADR_IS_FFT`; used only for pop side effects.
- `FFT_DATA` out 8: read data for the addressed register, combinational.
- `S_DATA` out 8: sample to the FFT core.
- `S_VALID` out 1: sample valid.
- `S_READY` in 1: core accepts the sample.
- `S_LAST` out 1: marks the final sample of the frame.
- `R_DATA` in 8: result from the core.
- `R_VALID` in 1: result valid.
- `R_LAST` in 1: final result of the frame.
- `R_READY` out 1: block can accept a result; equals not OUT_FULL.
- `IRQ` out 1: `IRQ_EN & DONE`.

## Operation
- Register map, by offset:
  - 0, CTRL (R/W): bit0 START (self-clearing, reads 0), bit1 CLR (self-clearing, reads 0), bit7 IRQ_EN (held).
  - 1, STATUS: bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 IN_FULL (RO), bit3 OUT_EMPTY (RO), bit4 OVERFLOW (sticky, W1C).
  - 2, IN_DATA (WO): a write pushes one sample into the input FIFO. Reads return 0x00.
  - 3, OUT_DATA (RO): reads the output FIFO head, or 0x00 when empty. `FFT_READ` at this offset pops one entry.
  - 4, IN_COUNT: zero-extended count, 0–8.
  - 5, OUT_COUNT: zero-extended count, 0–8.
  - 6–7: reserved; reads return 0x00 and writes are ignored.
- FSM states are IDLE, STREAM, COLLECT.
  - IDLE: START=1 with IN_COUNT≠0 → STREAM and BUSY=1. START with an empty input FIFO is ignored.
  - STREAM: `S_VALID`=1 with `S_DATA` = input FIFO head. Each cycle where `S_VALID & S_READY`, one entry pops. `S_LAST`=1 when IN_COUNT==1. The handshake on the last sample → COLLECT.
  - COLLECT: each cycle where `R_VALID & R_READY`, `R_DATA` pushes to the output FIFO. That handshake with `R_LAST`=1 → IDLE, BUSY=0, DONE=1.
- `R_READY` is 0 when the output FIFO is full, so the core is stalled and no data is lost. `R_READY` is ungated by state; results outside COLLECT are still accepted and pushed.
- A push to IN_DATA while the input FIFO is full, or while BUSY=1, is dropped and sets OVERFLOW.
- A pop of OUT_DATA while the output FIFO is empty has no effect.
- CLR empties both FIFOs and forces the FSM to IDLE in the next cycle. BUSY clears, DONE is not set, and OVERFLOW and IRQ_EN are kept. CLR wins over START if both are written together.
- START while BUSY=1 is ignored.
- In the same cycle, a CPU pop and an engine push to the output FIFO both take effect; the count is unchanged. Likewise a CPU push (IDLE only) and an engine pop cannot collide on the input FIFO.
- FIFOs are strict FIFO order. Pointers wrap modulo DEPTH, and count disambiguates the full and empty states.

## Timing
- Reset values:
  - All FIFO pointers and counts are 0, the FSM is IDLE, and DONE, OVERFLOW and IRQ_EN are 0.
  - Outputs: `S_VALID`=0, `S_LAST`=0, `S_DATA`=0x00, `R_READY`=1, `IRQ`=0.
  - STATUS reads 0x08.
- `FFT_DATA` follows `ADR` and register state combinationally in the same cycle, with no wait states.
- A write with `FFT_WRITE` at edge N is visible in register state after edge N.
- START written at edge N: `S_VALID`=1 from after edge N.
- The last `S` handshake at edge M gives state COLLECT from M+1.
- The `R_LAST` handshake at edge K: BUSY=0, DONE=1 and `IRQ` (if enabled) are all visible after edge K.
- A pop at edge N: `FFT_DATA` at offset 3 shows the next entry after N.
- `RESET` asserted mid-frame clears everything immediately, regardless of `CLK`, and the FSM sits in IDLE.

## Test plan
- **Reset values:** assert `RESET` → STATUS=0x08, `S_VALID`=0, `R_READY`=1, `IRQ`=0.
- **Full frame:**
  - Stimulus: push 0x11,0x22,0x33,0x44; write CTRL=0x81. The core holds `S_READY`=1, then returns 0xA0–0xA3 with `R_LAST` on 0xA3.
  - Required: `S_DATA` sequence 0x11..0x44 with `S_LAST` only on 0x44.
  - Required: after the frame, STATUS=0x02, `IRQ`=1, and OUT_COUNT=4.
  - Required: four reads of offset 3 return 0xA0..0xA3, then 0x00.
- **Input overflow:** push 9 samples in IDLE → IN_COUNT=8, STATUS bit2=1, bit4=1. Writing STATUS=0x10 clears bit4.
- **Backpressure:** core sends 9 results without the CPU popping → `R_READY`=0 after 8 are accepted. One CPU pop → `R_READY`=1 and the 9th result is accepted, with OUT_COUNT=8.
- **CLR mid-frame:** START with 8 samples and `S_READY` toggling; write CTRL=0x02 after 3 handshakes → next cycle BUSY=0, `S_VALID`=0, both counts 0, DONE=0.
- **Async reset mid-operation:** `RESET` pulse between `CLK` edges during COLLECT → `S_VALID`=0 and `IRQ`=0 before the next edge; STATUS=0x08.

Source files
------------

// File: rtl/fft_regfile.sv
// ---------------------------------------------------------------------------
// fft_regfile
//
// CPU-facing register window for the FFT accelerator (addresses 0xF8-0xFF).
// Input samples written by the CPU are buffered in an input FIFO. A small
// sequencer streams a whole frame to the FFT core and collects the results
// into an output FIFO, which the CPU then drains through OUT_DATA.
//
// Ports
//   CLK, RESET        system clock, asynchronous active-high reset
//   ADR[2:0]          register offset within the window
//   WRITE_DATA[7:0]   CPU write data
//   FFT_WRITE         one-cycle write strobe
//   FFT_READ          one-cycle read strobe (only used for the OUT_DATA pop)
//   FFT_DATA[7:0]     combinational read data for the addressed register
//   S_DATA/S_VALID/S_READY/S_LAST   sample stream towards the core
//   R_DATA/R_VALID/R_READY/R_LAST   result stream from the core
//   IRQ               IRQ_EN & DONE
//
// Register map
//   0 CTRL      bit0 START (self-clearing), bit1 CLR (self-clearing), bit7 IRQ_EN
//   1 STATUS    bit0 BUSY, bit1 DONE (W1C), bit2 IN_FULL, bit3 OUT_EMPTY,
//               bit4 OVERFLOW (W1C)
//   2 IN_DATA   write pushes a sample, reads 0
//   3 OUT_DATA  output FIFO head (0 when empty), FFT_READ pops
//   4 IN_COUNT, 5 OUT_COUNT, 6-7 reserved
// ---------------------------------------------------------------------------
module fft_regfile #(
    parameter int DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] ADR,
    input  logic [7:0] WRITE_DATA,
    input  logic       FFT_WRITE,
    input  logic       FFT_READ,
    output logic [7:0] FFT_DATA,
    output logic [7:0] S_DATA,
    output logic       S_VALID,
    input  logic       S_READY,
    output logic       S_LAST,
    input  logic [7:0] R_DATA,
    input  logic       R_VALID,
    input  logic       R_LAST,
    output logic       R_READY,
    output logic       IRQ
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        COLLECT
    } state_t;

    state_t state_q, state_d;

    // FIFO storage and bookkeeping
    logic [7:0]    inMem_q  [DEPTH];
    logic [7:0]    outMem_q [DEPTH];
    logic [AW-1:0] inWr_q, inWr_d, inRd_q, inRd_d;
    logic [AW-1:0] outWr_q, outWr_d, outRd_q, outRd_d;
    logic [CW-1:0] inCount_q, inCount_d, outCount_q, outCount_d;

    // Control / status flags
    logic irqEn_q, irqEn_d;
    logic done_q, done_d;
    logic ovf_q, ovf_d;

    // Decoded strobes and handshakes
    logic wrCtrl, wrStatus, wrInData, rdOutData;
    logic clrReq, startReq;
    logic busy, inFull, inEmpty, outFull, outEmpty;
    logic sHs, rHs;
    logic inPush, inPop, inOverflow, outPush, outPop;
    logic frameDone;

    // Address decode, FIFO flags and handshake qualification. CLR is given
    // priority over START so a combined write only clears.
    always_comb begin
        wrCtrl     = FFT_WRITE && (ADR == 3'd0);
        wrStatus   = FFT_WRITE && (ADR == 3'd1);
        wrInData   = FFT_WRITE && (ADR == 3'd2);
        rdOutData  = FFT_READ  && (ADR == 3'd3);

        clrReq     = wrCtrl && WRITE_DATA[1];
        startReq   = wrCtrl && WRITE_DATA[0] && !WRITE_DATA[1];

        busy       = (state_q != IDLE);
        inFull     = (inCount_q  == CW'(DEPTH));
        inEmpty    = (inCount_q  == '0);
        outFull    = (outCount_q == CW'(DEPTH));
        outEmpty   = (outCount_q == '0);

        sHs        = (state_q == STREAM) && S_READY;
        rHs        = R_VALID && !outFull;

        // The CPU may only feed the input FIFO while the engine is idle.
        inPush     = wrInData && !inFull && !busy;
        inOverflow = wrInData && (inFull || busy);
        inPop      = sHs;
        outPush    = rHs;
        outPop     = rdOutData && !outEmpty;

        frameDone  = (state_q == COLLECT) && rHs && R_LAST && !clrReq;
    end

    // Sequencer next-state: stream the buffered frame, then wait for the
    // core's final result. CLR overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (startReq && !inEmpty) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (sHs && (inCount_q == CW'(1))) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (rHs && R_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clrReq) begin
            state_d = IDLE;
        end
    end

    // FIFO pointer/count next-state. Pointers wrap naturally because DEPTH
    // is a power of two; the count tells full from empty. A simultaneous
    // push and pop leave the count unchanged.
    always_comb begin
        inWr_d     = inWr_q;
        inRd_d     = inRd_q;
        inCount_d  = inCount_q;
        outWr_d    = outWr_q;
        outRd_d    = outRd_q;
        outCount_d = outCount_q;

        if (inPush) begin
            inWr_d = inWr_q + AW'(1);
        end
        if (inPop) begin
            inRd_d = inRd_q + AW'(1);
        end
        inCount_d = inCount_q + CW'(inPush) - CW'(inPop);

        if (outPush) begin
            outWr_d = outWr_q + AW'(1);
        end
        if (outPop) begin
            outRd_d = outRd_q + AW'(1);
        end
        outCount_d = outCount_q + CW'(outPush) - CW'(outPop);

        if (clrReq) begin
            inWr_d     = '0;
            inRd_d     = '0;
            inCount_d  = '0;
            outWr_d    = '0;
            outRd_d    = '0;
            outCount_d = '0;
        end
    end

    // Sticky flags. A frame completing in the same cycle as a W1C of DONE
    // leaves DONE set so the completion is not lost.
    always_comb begin
        irqEn_d = irqEn_q;
        done_d  = done_q;
        ovf_d   = ovf_q;

        if (wrCtrl) begin
            irqEn_d = WRITE_DATA[7];
        end
        if (wrStatus && WRITE_DATA[1]) begin
            done_d = 1'b0;
        end
        if (wrStatus && WRITE_DATA[4]) begin
            ovf_d = 1'b0;
        end
        if (frameDone) begin
            done_d = 1'b1;
        end
        if (inOverflow) begin
            ovf_d = 1'b1;
        end
    end

    // State, pointer, count and flag registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            inWr_q     <= '0;
            inRd_q     <= '0;
            inCount_q  <= '0;
            outWr_q    <= '0;
            outRd_q    <= '0;
            outCount_q <= '0;
            irqEn_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inWr_q     <= inWr_d;
            inRd_q     <= inRd_d;
            inCount_q  <= inCount_d;
            outWr_q    <= outWr_d;
            outRd_q    <= outRd_d;
            outCount_q <= outCount_d;
            irqEn_q    <= irqEn_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO storage needs no reset: every read path is gated by the count,
    // so stale contents are never visible.
    always_ff @(posedge CLK) begin
        if (inPush) begin
            inMem_q[inWr_q] <= WRITE_DATA;
        end
        if (outPush) begin
            outMem_q[outWr_q] <= R_DATA;
        end
    end

    // Stream outputs. S_DATA is forced to zero outside STREAM so the bus
    // idles cleanly.
    always_comb begin
        S_VALID = (state_q == STREAM);
        S_DATA  = S_VALID ? inMem_q[inRd_q] : 8'h00;
        S_LAST  = S_VALID && (inCount_q == CW'(1));
        R_READY = !outFull;
        IRQ     = irqEn_q && done_q;
    end

    // CPU read mux, purely combinational so reads need no wait states.
    always_comb begin
        FFT_DATA = 8'h00;
        case (ADR)
            3'd0: FFT_DATA = {irqEn_q, 7'b0};
            3'd1: FFT_DATA = {3'b000, ovf_q, outEmpty, inFull, done_q, busy};
            3'd3: FFT_DATA = outEmpty ? 8'h00 : outMem_q[outRd_q];
            3'd4: FFT_DATA = {{(8 - CW){1'b0}}, inCount_q};
            3'd5: FFT_DATA = {{(8 - CW){1'b0}}, outCount_q};
            default: FFT_DATA = 8'h00;
        endcase
    end

endmodule
